// File: rtl/puf_ctrl_pkg.sv
// Shared types and constants for the PUF challenge/response controller and its UART wrappers.
// No logic; width and default constants only.
// No flow control.
package puf_ctrl_pkg;

    localparam int CRP_W = 16;
    localparam logic [CRP_W-1:0] CHECK_WORD_DEFAULT = 16'h1234;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_FIRE,
        ST_SAMPLE,
        ST_VOTE,
        ST_SEND,
        ST_WAIT_TX
    } state_t;

endpackage

// File: rtl/puf_bit_voter.sv
// Per-bit ones counter across EVALS PUF samples with majority and unanimity decode.
// Count updates one cycle after accumulate; decode is combinational from the count.
// No flow control; the sequencer guarantees at most EVALS accumulates between clears.
module puf_bit_voter #(
    parameter int EVALS = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic accumulate,
    input  logic sample,
    output logic majority,
    output logic unstable
);

    localparam int CW = $clog2(EVALS + 1);
    localparam logic [CW-1:0] HALF = CW'(EVALS / 2);
    localparam logic [CW-1:0] FULL = CW'(EVALS);

    logic [CW-1:0] ones_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ones_cnt <= '0;
        end else if (clear) begin
            ones_cnt <= '0;
        end else if (accumulate && sample) begin
            ones_cnt <= ones_cnt + 1'b1;
        end
    end

    assign majority = (ones_cnt > HALF);
    assign unstable = (ones_cnt != '0) && (ones_cnt != FULL);

endmodule

// File: rtl/puf_crp_sequencer.sv
// Sequences EVALS arm/fire/sample rounds on the arbiter PUF, majority-votes the word, hands it to TX.
// Latency EVALS*(2*SETTLE_CYCLES+1)+2 cycles to tx_start (1 in check mode); holds in WAIT_TX until tx_done.
// Challenges arriving while busy are dropped and flagged on overrun.
module puf_crp_sequencer
    import puf_ctrl_pkg::*;
#(
    parameter int               SETTLE_CYCLES = 8,
    parameter int               EVALS         = 5,
    parameter logic [CRP_W-1:0] CHECK_WORD    = CHECK_WORD_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             challenge_valid,
    input  logic [CRP_W-1:0] challenge,
    input  logic             check,
    input  logic [CRP_W-1:0] puf_response,
    input  logic             tx_done,
    output logic [CRP_W-1:0] puf_challenge,
    output logic             puf_trigger,
    output logic [CRP_W-1:0] tx_data,
    output logic             tx_start,
    output logic             busy,
    output logic             overrun,
    output logic [CRP_W-1:0] unstable_mask
);

    localparam int EW = $clog2(EVALS + 1);
    localparam logic [7:0]    SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [EW-1:0] EVALS_W     = EW'(EVALS);

    state_t          state;
    state_t          state_nxt;
    logic [7:0]      settle_cnt;
    logic [EW-1:0]   eval_cnt;
    logic [EW-1:0]   eval_inc;
    logic            accept;
    logic            sample_en;
    logic            settle_done;
    logic [CRP_W-1:0] vote_majority;
    logic [CRP_W-1:0] vote_unstable;

    assign settle_done = (settle_cnt == SETTLE_LAST);
    assign eval_inc    = eval_cnt + 1'b1;

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        sample_en = 1'b0;
        case (state)
            ST_IDLE: begin
                if (challenge_valid) begin
                    accept    = 1'b1;
                    state_nxt = check ? ST_SEND : ST_ARM;
                end
            end
            ST_ARM:     if (settle_done) state_nxt = ST_FIRE;
            ST_FIRE:    if (settle_done) state_nxt = ST_SAMPLE;
            ST_SAMPLE: begin
                sample_en = 1'b1;
                state_nxt = (eval_inc < EVALS_W) ? ST_ARM : ST_VOTE;
            end
            ST_VOTE:    state_nxt = ST_SEND;
            ST_SEND:    state_nxt = ST_WAIT_TX;
            ST_WAIT_TX: if (tx_done) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Settle counter restarts on every state change so ARM and FIRE each last exactly SETTLE_CYCLES.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            settle_cnt <= '0;
        end else if (state_nxt != state) begin
            settle_cnt <= '0;
        end else if (state == ST_ARM || state == ST_FIRE) begin
            settle_cnt <= settle_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eval_cnt <= '0;
        end else if (accept) begin
            eval_cnt <= '0;
        end else if (sample_en) begin
            eval_cnt <= eval_inc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            puf_challenge <= '0;
            tx_data       <= '0;
            unstable_mask <= '0;
        end else begin
            if (accept) begin
                puf_challenge <= challenge;
            end
            if (accept && check) begin
                tx_data       <= CHECK_WORD;
                unstable_mask <= '0;
            end else if (state == ST_VOTE) begin
                tx_data       <= vote_majority;
                unstable_mask <= vote_unstable;
            end
        end
    end

    for (genvar i = 0; i < CRP_W; i++) begin : g_voter
        puf_bit_voter #(
            .EVALS (EVALS)
        ) u_voter (
            .clk        (clk),
            .rst        (rst),
            .clear      (accept),
            .accumulate (sample_en),
            .sample     (puf_response[i]),
            .majority   (vote_majority[i]),
            .unstable   (vote_unstable[i])
        );
    end

    // Trigger stays high through SAMPLE so the response is read after a full high settle phase.
    assign puf_trigger = (state == ST_FIRE) || (state == ST_SAMPLE);
    assign tx_start    = (state == ST_SEND);
    assign busy        = (state != ST_IDLE);
    assign overrun     = challenge_valid && (state != ST_IDLE);

endmodule
